// File: rtl/timer_pkg.sv
// Shared BCD types and helpers for the on-screen game timer.
package timer_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Preset nibbles above 9 are not valid BCD; pin them to 9.
    function automatic bcd_t bcd_clamp(input bcd_t v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the timer: holds its value and ripples carry (up) or
// borrow (down) to the next more-significant digit.
module bcd_digit
    import timer_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       en_i,
    input  logic       down_i,
    input  logic       cin_i,
    output logic       cout_o,
    output logic [3:0] digit_o
);

    bcd_t digit_q;
    bcd_t digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clear_i) begin
            digit_d = '0;
        end else if (load_i) begin
            digit_d = bcd_clamp(load_val_i);
        end else if (en_i && cin_i) begin
            if (down_i) begin
                digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
            end else begin
                digit_d = (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
            end
        end
    end

    // Carry/borrow out only depends on the incoming carry and this digit's value.
    assign cout_o  = cin_i && (down_i ? (digit_q == 4'd0) : (digit_q == BCD_MAX));
    assign digit_o = digit_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/bcd_timer_display.sv
// N-digit BCD up/down game timer with prescaled tick, pause/clear/load,
// expiry flag and per-pixel digit-cell hit test for the font ROM path.
module bcd_timer_display
    import timer_pkg::*;
#(
    parameter int NUM_DIGITS  = 3,
    parameter int CLK_HZ      = 50000000,
    parameter int TICK_HZ     = 1,
    parameter int ORIGIN_X    = 540,
    parameter int ORIGIN_Y    = 0,
    parameter int DIGIT_W     = 32,
    parameter int DIGIT_H     = 32,
    parameter int DIGIT_PITCH = 32
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Run,
    input  logic                    Down,
    input  logic                    Clear,
    input  logic                    Load,
    input  logic [4*NUM_DIGITS-1:0] Load_val,
    input  logic [9:0]              DrawX,
    input  logic [9:0]              DrawY,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    tick,
    output logic                    wrap,
    output logic                    expired,
    output logic                    is_timer,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_sel,
    output logic [3:0]              digit_val
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PRE_W-1:0]        pre_q;
    logic [PRE_W-1:0]        pre_d;
    logic                    tick_q;
    logic                    wrap_q;
    logic                    wrap_d;
    logic                    expired_q;
    logic                    expired_d;
    logic                    step;
    logic                    step_eff;
    logic                    all_zero;
    logic                    is_one;
    logic                    digit_en;
    logic [NUM_DIGITS:0]     chain;
    logic [4*NUM_DIGITS-1:0] digits_w;

    // A step that coincides with Clear or Load is swallowed entirely.
    assign step     = Run && (pre_q == PRE_W'(DIV - 1));
    assign step_eff = step && !Clear && !Load;
    assign all_zero = (digits_w == '0);
    assign is_one   = (digits_w == (4*NUM_DIGITS)'(1));
    // Down-counting saturates at zero: the tick still fires but digits hold.
    assign digit_en = step_eff && !(Down && all_zero);

    always_comb begin
        pre_d = pre_q;
        if (Clear || Load || step) begin
            pre_d = '0;
        end else if (Run) begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    // With Down=0 the top of the chain means every digit is 9.
    assign wrap_d = step_eff && !Down && chain[NUM_DIGITS];

    always_comb begin
        expired_d = expired_q;
        if (Clear || Load) begin
            expired_d = 1'b0;
        end else if (step_eff) begin
            if (Down) begin
                expired_d = expired_q || all_zero || is_one;
            end else begin
                expired_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pre_q     <= '0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            tick_q    <= step_eff;
            wrap_q    <= wrap_d;
            expired_q <= expired_d;
        end
    end

    assign chain[0] = 1'b1;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        bcd_digit u_digit (
            .clk_i      (Clk),
            .rst_i      (Reset),
            .clear_i    (Clear),
            .load_i     (Load),
            .load_val_i (Load_val[4*gi +: 4]),
            .en_i       (digit_en),
            .down_i     (Down),
            .cin_i      (chain[gi]),
            .cout_o     (chain[gi+1]),
            .digit_o    (digits_w[4*gi +: 4])
        );
    end

    assign digits  = digits_w;
    assign tick    = tick_q;
    assign wrap    = wrap_q;
    assign expired = expired_q;

    // Pixel offsets are formed as 33-bit signed differences so left/top of the origin is negative.
    logic signed [32:0]    dy;
    logic                  y_hit;
    logic [NUM_DIGITS-1:0] hit;

    assign dy    = $signed({23'd0, DrawY}) - $signed(33'(ORIGIN_Y));
    assign y_hit = !dy[32] && (dy < $signed(33'(DIGIT_H)));

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_cell
        localparam int X0 = ORIGIN_X + (NUM_DIGITS - 1 - gi) * DIGIT_PITCH;
        logic signed [32:0] dx;
        assign dx      = $signed({23'd0, DrawX}) - $signed(33'(X0));
        assign hit[gi] = y_hit && !dx[32] && (dx < $signed(33'(DIGIT_W)));
    end

    always_comb begin
        is_timer  = 1'b0;
        digit_sel = '0;
        digit_val = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (hit[i]) begin
                is_timer  = 1'b1;
                digit_sel = SEL_W'(i);
                digit_val = digits_w[4*i +: 4];
            end
        end
    end

endmodule

// File: tb/tb_bcd_timer_display.sv
// Scoreboarded bench for the BCD timer: expected per-tick results are queued
// when stimulus is applied and popped as each tick arrives.
module tb_bcd_timer_display;

    logic        Clk = 1'b0;
    logic        Reset, Run, Down, Clear, Load;
    logic [11:0] Load_val;
    logic [9:0]  DrawX, DrawY;
    logic [11:0] digits;
    logic        tick, wrap, expired, is_timer;
    logic [1:0]  digit_sel;
    logic [3:0]  digit_val;

    typedef struct packed {
        logic [11:0] d;
        logic        w;
        logic        e;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 Clk = ~Clk;

    bcd_timer_display #(
        .NUM_DIGITS (3),
        .CLK_HZ     (10),
        .TICK_HZ    (1)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Run       (Run),
        .Down      (Down),
        .Clear     (Clear),
        .Load      (Load),
        .Load_val  (Load_val),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .digits    (digits),
        .tick      (tick),
        .wrap      (wrap),
        .expired   (expired),
        .is_timer  (is_timer),
        .digit_sel (digit_sel),
        .digit_val (digit_val)
    );

    function automatic logic [11:0] to_bcd(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic wait_tick(output int cyc, output bit got);
        got = 1'b0;
        cyc = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge Clk);
            cyc++;
            if (tick === 1'b1) got = 1'b1;
        end
    endtask

    task automatic load_value(input logic [11:0] v, input logic dn);
        @(negedge Clk);
        Run = 1'b0; Load = 1'b1; Load_val = v; Down = dn;
        @(negedge Clk);
        Load = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1; Run = 1'b1; Down = 1'b0; Clear = 1'b0; Load = 1'b0;
        Load_val = '0; DrawX = '0; DrawY = 10'd100;
        repeat (2) @(negedge Clk);
        vectors++;
        if (digits !== 12'h000) begin miscompares++; $display("FAIL reset_digits got=%h exp=000", digits); end
        vectors++;
        if (tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick got=%b exp=0", tick); end
        vectors++;
        if (wrap !== 1'b0) begin miscompares++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
        vectors++;
        if (expired !== 1'b0) begin miscompares++; $display("FAIL reset_expired got=%b exp=0", expired); end
        $display("reset: digits=%h tick=%b wrap=%b expired=%b", digits, tick, wrap, expired);
    endtask

    task automatic test_count_up;
        int   cyc;
        bit   got;
        exp_t e;
        Reset = 1'b0;
        for (int i = 1; i <= 10; i++) exp_q.push_back('{d: to_bcd(i), w: 1'b0, e: 1'b0});
        while (exp_q.size() != 0) begin
            wait_tick(cyc, got);
            e = exp_q.pop_front();
            vectors++;
            if (!got || cyc != 10) begin
                miscompares++;
                $display("FAIL count_period got=%0d cycles (tick=%b) exp=10", cyc, got);
            end
            vectors++;
            if (digits !== e.d || wrap !== e.w || expired !== e.e) begin
                miscompares++;
                $display("FAIL count_up got=%h/%b/%b exp=%h/%b/%b", digits, wrap, expired, e.d, e.w, e.e);
            end
            $display("count_up: tick after %0d cycles digits=%h", cyc, digits);
        end
    endtask

    task automatic test_up_wrap;
        int   cyc;
        bit   got;
        exp_t e;
        load_value(12'h998, 1'b0);
        vectors++;
        if (digits !== 12'h998) begin miscompares++; $display("FAIL wrap_load got=%h exp=998", digits); end
        Run = 1'b1;
        exp_q.push_back('{d: 12'h999, w: 1'b0, e: 1'b0});
        exp_q.push_back('{d: 12'h000, w: 1'b1, e: 1'b0});
        while (exp_q.size() != 0) begin
            wait_tick(cyc, got);
            e = exp_q.pop_front();
            vectors++;
            if (!got || digits !== e.d || wrap !== e.w || expired !== e.e) begin
                miscompares++;
                $display("FAIL up_wrap got=%h/%b/%b tick=%b exp=%h/%b/%b", digits, wrap, expired, got, e.d, e.w, e.e);
            end
            $display("up_wrap: digits=%h wrap=%b", digits, wrap);
        end
        @(negedge Clk);
        vectors++;
        if (wrap !== 1'b0 || tick !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_pulse_width got wrap=%b tick=%b exp=0/0", wrap, tick);
        end
    endtask

    task automatic test_down_expire;
        int   cyc;
        bit   got;
        exp_t e;
        load_value(12'h002, 1'b1);
        Run = 1'b1;
        exp_q.push_back('{d: 12'h001, w: 1'b0, e: 1'b0});
        exp_q.push_back('{d: 12'h000, w: 1'b0, e: 1'b1});
        exp_q.push_back('{d: 12'h000, w: 1'b0, e: 1'b1});
        while (exp_q.size() != 0) begin
            wait_tick(cyc, got);
            e = exp_q.pop_front();
            vectors++;
            if (!got || digits !== e.d || wrap !== e.w || expired !== e.e) begin
                miscompares++;
                $display("FAIL down_expire got=%h/%b/%b tick=%b exp=%h/%b/%b", digits, wrap, expired, got, e.d, e.w, e.e);
            end
            $display("down: digits=%h expired=%b", digits, expired);
        end
        @(negedge Clk);
        Run = 1'b0; Clear = 1'b1;
        @(negedge Clk);
        Clear = 1'b0;
        vectors++;
        if (expired !== 1'b0 || digits !== 12'h000) begin
            miscompares++;
            $display("FAIL clear got=%h/%b exp=000/0", digits, expired);
        end
        $display("clear: digits=%h expired=%b", digits, expired);
    endtask

    task automatic test_pause;
        int   cyc;
        bit   got;
        exp_t e;
        Down = 1'b0;
        @(negedge Clk);
        Run = 1'b1;
        repeat (6) @(negedge Clk);
        Run = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            vectors++;
            if (tick !== 1'b0) begin miscompares++; $display("FAIL pause_tick cycle=%0d got=%b exp=0", k, tick); end
        end
        Run = 1'b1;
        exp_q.push_back('{d: 12'h001, w: 1'b0, e: 1'b0});
        wait_tick(cyc, got);
        e = exp_q.pop_front();
        vectors++;
        if (!got || cyc != 4 || digits !== e.d) begin
            miscompares++;
            $display("FAIL pause_resume got=%0d cycles digits=%h exp=4 cycles digits=%h", cyc, digits, e.d);
        end
        $display("pause: resumed tick after %0d cycles digits=%h", cyc, digits);
    endtask

    task automatic test_load_collide;
        int   cyc;
        bit   got;
        exp_t e;
        repeat (9) @(negedge Clk);
        Load = 1'b1; Load_val = 12'hA5F;
        @(negedge Clk);
        Load = 1'b0;
        vectors++;
        if (digits !== 12'h959 || tick !== 1'b0) begin
            miscompares++;
            $display("FAIL load_collide got=%h tick=%b exp=959 tick=0", digits, tick);
        end
        $display("load_collide: digits=%h tick=%b", digits, tick);
        exp_q.push_back('{d: 12'h960, w: 1'b0, e: 1'b0});
        wait_tick(cyc, got);
        e = exp_q.pop_front();
        vectors++;
        if (!got || cyc != 10 || digits !== e.d) begin
            miscompares++;
            $display("FAIL load_restart got=%0d cycles digits=%h exp=10 cycles digits=%h", cyc, digits, e.d);
        end
        DrawX = 10'd604; DrawY = 10'd0;
        #2 Reset = 1'b1;
        #1;
        vectors++;
        if (digits !== 12'h000 || tick !== 1'b0 || wrap !== 1'b0 || expired !== 1'b0 || digit_val !== 4'd0) begin
            miscompares++;
            $display("FAIL async_reset got=%h/%b/%b/%b val=%0d exp=000/0/0/0 val=0", digits, tick, wrap, expired, digit_val);
        end
        $display("async_reset: digits=%h tick=%b", digits, tick);
    endtask

    task automatic test_pixel;
        int px[8][5] = '{
            '{540, 0, 1, 2, 1}, '{571, 0, 1, 2, 1}, '{572, 15, 1, 1, 2}, '{604, 31, 1, 0, 3},
            '{635, 31, 1, 0, 3}, '{636, 0, 0, 0, 0}, '{604, 32, 0, 0, 0}, '{539, 5, 0, 0, 0}
        };
        @(negedge Clk);
        Reset = 1'b0;
        load_value(12'h123, 1'b0);
        for (int i = 0; i < 8; i++) begin
            DrawX = 10'(px[i][0]);
            DrawY = 10'(px[i][1]);
            #1;
            vectors++;
            if (is_timer !== 1'(px[i][2]) || digit_sel !== 2'(px[i][3]) || digit_val !== 4'(px[i][4])) begin
                miscompares++;
                $display("FAIL pixel x=%0d y=%0d got=%b/%0d/%0d exp=%0d/%0d/%0d", px[i][0], px[i][1],
                         is_timer, digit_sel, digit_val, px[i][2], px[i][3], px[i][4]);
            end
            $display("pixel: x=%0d y=%0d is_timer=%b sel=%0d val=%0d", px[i][0], px[i][1], is_timer, digit_sel, digit_val);
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_up_wrap();
        test_down_expire();
        test_pause();
        test_load_collide();
        test_pixel();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
